// File: rtl/led_pattern_engine.sv
// rtl/led_pattern_engine.sv - step-driven LED pattern generator with programmable prescaler
module led_pattern_engine #(
    parameter int WIDTH       = 8,
    parameter int DIV_W       = 24,
    parameter int COUNT_START = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ss,
    input  logic [2:0]       mode,
    input  logic [DIV_W-1:0] div,
    input  logic             loop,
    input  logic             restart,
    output logic [WIDTH-1:0] led,
    output logic             done,
    output logic             step
);
    localparam int H = WIDTH / 2;
    localparam logic [WIDTH-1:0] ONES  = '1;
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
    localparam logic [WIDTH-1:0] CLOAD = WIDTH'(COUNT_START);

    localparam logic [2:0] M_FILL      = 3'd0;
    localparam logic [2:0] M_SHIFT_OUT = 3'd1;
    localparam logic [2:0] M_COUNTDOWN = 3'd2;
    localparam logic [2:0] M_CONVERGE  = 3'd3;
    localparam logic [2:0] M_BOUNCE    = 3'd4;

    // FILL uses START/RUN as the up phase; BOUNCE uses RUN = up, DOWN = down
    typedef enum logic [1:0] {PH_START, PH_RUN, PH_DOWN} phase_t;

    phase_t           phase_q, phase_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [2:0]       mode_q, mode_d;
    logic             done_q, done_d;
    logic             step_q, step_d;

    logic             clear, tick, mode_valid;
    logic [WIDTH-1:0] shl, shr, fill_up, conv, dec;

    assign clear      = restart || (mode != mode_q);
    assign tick       = (cnt_q >= div);
    assign mode_valid = (mode_q <= M_BOUNCE);

    assign shl     = {led_q[WIDTH-2:0], 1'b0};
    assign shr     = {1'b0, led_q[WIDTH-1:1]};
    assign fill_up = {led_q[WIDTH-2:0], 1'b1};
    assign conv    = {1'b1, led_q[WIDTH-1:H+1], led_q[H-2:0], 1'b1};
    assign dec     = led_q - ONE;

    always_comb begin
        phase_d = phase_q;
        led_d   = led_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        step_d  = 1'b0;
        mode_d  = mode;

        if (clear) begin
            phase_d = PH_START;
            led_d   = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
        end else if (!ss) begin
            cnt_d = tick ? '0 : cnt_q + 1'b1;
            if (tick && mode_valid) begin
                step_d = 1'b1;
                if (!done_q) begin
                    case (mode_q)
                        M_FILL: begin
                            if (phase_q == PH_DOWN) begin
                                led_d = shr;
                                if (shr == '0) begin
                                    if (loop) phase_d = PH_RUN;
                                    else      done_d  = 1'b1;
                                end
                            end else begin
                                led_d   = fill_up;
                                phase_d = (fill_up == ONES) ? PH_DOWN : PH_RUN;
                            end
                        end
                        M_SHIFT_OUT: begin
                            if (phase_q == PH_START) begin
                                led_d   = ONES;
                                phase_d = PH_RUN;
                            end else begin
                                led_d = shl;
                                if (shl == '0) begin
                                    if (loop) phase_d = PH_START;
                                    else      done_d  = 1'b1;
                                end
                            end
                        end
                        M_COUNTDOWN: begin
                            if (phase_q == PH_START) begin
                                led_d   = CLOAD;
                                phase_d = PH_RUN;
                            end else begin
                                led_d = dec;
                                if (dec == ONE) begin
                                    if (loop) phase_d = PH_START;
                                    else      done_d  = 1'b1;
                                end
                            end
                        end
                        M_CONVERGE: begin
                            if (led_q == ONES) begin
                                led_d = '0;
                                if (!loop) done_d = 1'b1;
                            end else begin
                                led_d = conv;
                            end
                        end
                        M_BOUNCE: begin
                            if (phase_q == PH_START) begin
                                led_d   = ONE;
                                phase_d = PH_RUN;
                            end else if (phase_q == PH_RUN) begin
                                led_d = shl;
                                if (shl[WIDTH-1]) phase_d = PH_DOWN;
                            end else begin
                                led_d = shr;
                                if (shr[0]) phase_d = PH_RUN;
                            end
                        end
                        default: led_d = '0;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase_q <= PH_START;
            led_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= M_FILL;
            done_q  <= 1'b0;
            step_q  <= 1'b0;
        end else begin
            phase_q <= phase_d;
            led_q   <= led_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
            step_q  <= step_d;
        end
    end

    assign led  = led_q;
    assign done = done_q;
    assign step = step_q;
endmodule

// File: tb/tb_led_pattern_engine.sv
// tb/tb_led_pattern_engine.sv - directed self-checking bench for led_pattern_engine
module tb_led_pattern_engine;
    logic        clk = 1'b0;
    logic        reset;
    logic        ss;
    logic [2:0]  mode;
    logic [23:0] div;
    logic        loop;
    logic        restart;
    logic [7:0]  led;
    logic        done;
    logic        step;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] fill_seq [17] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
                                  8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00, 8'h01};
    logic [7:0] shift_seq [9] = '{8'hFF, 8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00};
    logic [7:0] conv_seq [5]  = '{8'h81, 8'hC3, 8'hE7, 8'hFF, 8'h00};
    logic [7:0] bnc_seq [16]  = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                                  8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};

    led_pattern_engine #(.WIDTH(8), .DIV_W(24), .COUNT_START(20)) dut (
        .clk     (clk),
        .reset   (reset),
        .ss      (ss),
        .mode    (mode),
        .div     (div),
        .loop    (loop),
        .restart (restart),
        .led     (led),
        .done    (done),
        .step    (step)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; ss = 1'b0; mode = 3'd0; div = 24'd0; loop = 1'b1; restart = 1'b0;
        @(negedge clk);
        check("rst_led", led, 0);
        check("rst_done", done, 0);
        check("rst_step", step, 0);
        reset = 1'b0;

        // fill/drain loop, one step per clock
        for (int i = 0; i < 17; i++) begin
            @(negedge clk);
            check("fill_led", led, fill_seq[i]);
            check("fill_step", step, 1);
        end
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            check("fill2_led", led, fill_seq[i]);
        end

        // mode change at led=1F, then SHIFT_OUT with div=2
        mode = 3'd1; div = 24'd2;
        @(negedge clk);
        check("chg_led", led, 0);
        check("chg_step", step, 0);
        repeat (2) begin
            @(negedge clk);
            check("chg_wait_led", led, 0);
            check("chg_wait_step", step, 0);
        end
        @(negedge clk);
        check("shift_first", led, 8'hFF);
        check("shift_first_step", step, 1);
        repeat (3) @(negedge clk);
        check("shift_second", led, 8'hFE);
        @(negedge clk);
        restart = 1'b1; div = 24'd0; loop = 1'b0;
        @(negedge clk);
        check("restart_led", led, 0);
        check("restart_done", done, 0);
        check("restart_step", step, 0);
        restart = 1'b0;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            check("shot_led", led, shift_seq[i]);
            check("shot_done", done, (i == 8) ? 1 : 0);
        end
        @(negedge clk);
        check("shot_hold_led", led, 0);
        check("shot_hold_done", done, 1);

        // one-shot countdown, div=3
        mode = 3'd2; div = 24'd3; loop = 1'b0;
        @(negedge clk);
        check("cd_clear_led", led, 0);
        check("cd_clear_done", done, 0);
        for (int k = 0; k < 20; k++) begin
            repeat (3) @(negedge clk);
            check("cd_gap_step", step, 0);
            @(negedge clk);
            check("cd_led", led, 20 - k);
            check("cd_step", step, 1);
            check("cd_done", done, (k == 19) ? 1 : 0);
        end
        for (int k = 0; k < 10; k++) begin
            repeat (4) @(negedge clk);
            check("cd_after_led", led, 1);
            check("cd_after_done", done, 1);
        end

        // one-shot converge
        mode = 3'd3; div = 24'd0;
        @(negedge clk);
        check("cv_clear_led", led, 0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("cv_led", led, conv_seq[i]);
            check("cv_done", done, (i == 4) ? 1 : 0);
        end
        @(negedge clk);
        check("cv_after_led", led, 0);
        check("cv_after_done", done, 1);

        // bounce with a 7-cycle hold
        mode = 3'd4; div = 24'd1;
        @(negedge clk);
        check("bn_clear_led", led, 0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bn_gap_step", step, 0);
            @(negedge clk);
            check("bn_led", led, bnc_seq[i]);
            check("bn_step", step, 1);
        end
        @(negedge clk);
        ss = 1'b1;
        repeat (7) begin
            @(negedge clk);
            check("hold_led", led, 8'h08);
            check("hold_step", step, 0);
        end
        ss = 1'b0;
        for (int i = 4; i < 16; i++) begin
            @(negedge clk);
            check("bn2_led", led, bnc_seq[i]);
            check("bn2_step", step, 1);
            check("bn2_done", done, 0);
            @(negedge clk);
            check("bn2_gap_step", step, 0);
        end

        // asynchronous reset between edges
        #2 reset = 1'b1;
        #1;
        check("arst_led", led, 0);
        check("arst_done", done, 0);
        check("arst_step", step, 0);
        @(negedge clk);
        reset = 1'b0;
        mode = 3'd5;
        @(negedge clk);
        check("rsv_clear_led", led, 0);
        repeat (10) begin
            @(negedge clk);
            check("rsv_led", led, 0);
            check("rsv_step", step, 0);
            check("rsv_done", done, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
